// File: rtl/ddr_rx_deser.sv
// ddr_rx_deser
// Receive side of the ODDR loopback path. The rise/fall bit pair captured each
// clk by the input DDR stage is treated as one serial stream (rise bit first).
// The receiver hunts for SYNC_WORD at either bit phase, locks, deserialises
// FRAME_LEN words per frame and buffers them in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   enable          receiver run; low forces IDLE and ignores the input
//   ddr_rise        earlier bit of the pair (captured on the rising edge)
//   ddr_fall        later bit of the pair (captured on the falling edge)
//   data_out        FIFO head word; holds its last value while data_valid=0
//   data_valid      data_out holds a word
//   data_ready      consumer accepts; pop on data_valid & data_ready
//   locked          frame alignment held
//   sync_ok         one-cycle pulse per matching sync word while locked
//   overflow        sticky: a word was dropped because the FIFO was full
//
// Optional feature macro: DDR_RX_ERR_CNT_EN
//   adds sync_err_cnt (16 bit) and lock_loss_cnt (8 bit) saturating counters,
//   both cleared when the receiver leaves IDLE.

module ddr_rx_deser #(
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int                FRAME_LEN  = 4,
  parameter int                MAX_MISS   = 3,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ddr_rise,
  input  logic              ddr_fall,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              locked,
  output logic              sync_ok,
  output logic              overflow
`ifdef DDR_RX_ERR_CNT_EN
  ,
  output logic [15:0]       sync_err_cnt,
  output logic [7:0]        lock_loss_cnt
`endif
);

  localparam int HALF  = WORD_W / 2;
  localparam int CYC_W = $clog2(HALF);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(HALF - 1);
  localparam logic [7:0]       WORD_LAST = 8'(FRAME_LEN - 1);
  localparam logic [3:0]       MISS_LAST = 4'(MAX_MISS - 1);
  localparam logic [PTR_W-1:0] MEM_FULL  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, HUNT, DATA, CHECK} state_t;

  state_t            state, state_nx;
  logic [WORD_W:0]   sr;
  logic              phase;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [7:0]        word_cnt;
  logic [3:0]        miss_cnt;

  logic              p0_hit, p1_hit, in_frame, word_done;
  logic [WORD_W-1:0] word;
  logic              lock_now, push, sync_hit, miss_event, lose_lock, leave_idle;

  // The FIFO head lives in data_out; mem holds the entries queued behind it,
  // so at most FIFO_DEPTH-1 mem slots are ever occupied.
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, mem_cnt;
  logic              pop, full, accept, mem_empty, mem_rd, mem_wr;

  assign p0_hit     = (sr[WORD_W-1:0] == SYNC_WORD);
  assign p1_hit     = (sr[WORD_W:1] == SYNC_WORD);
  assign word       = phase ? sr[WORD_W:1] : sr[WORD_W-1:0];
  assign in_frame   = (state == DATA) || (state == CHECK);
  assign word_done  = in_frame && (cyc_cnt == CYC_LAST);
  assign leave_idle = (state == IDLE) && enable;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle control strobes; P0 wins when both windows match
  always_comb begin
    state_nx   = state;
    lock_now   = 1'b0;
    push       = 1'b0;
    sync_hit   = 1'b0;
    miss_event = 1'b0;
    lose_lock  = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = HUNT;
        HUNT: begin
          if (p0_hit || p1_hit) begin
            lock_now = 1'b1;
            state_nx = DATA;
          end
        end
        DATA: begin
          if (word_done) begin
            push = 1'b1;
            if (word_cnt == WORD_LAST) state_nx = CHECK;
          end
        end
        CHECK: begin
          if (word_done) begin
            if (word == SYNC_WORD) begin
              sync_hit = 1'b1;
              state_nx = DATA;
            end else begin
              miss_event = 1'b1;
              if (miss_cnt == MISS_LAST) begin
                lose_lock = 1'b1;
                state_nx  = HUNT;
              end else begin
                state_nx = DATA;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Shift register, word/frame counters and lock status. Dropping enable
  // clears the shift register, which throws away any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      phase    <= 1'b0;
      cyc_cnt  <= '0;
      word_cnt <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
      sync_ok  <= 1'b0;
    end else begin
      sync_ok <= sync_hit;
      if (!enable) begin
        sr     <= '0;
        locked <= 1'b0;
      end else begin
        sr <= {sr[WORD_W-2:0], ddr_rise, ddr_fall};
        if (lock_now) begin
          phase    <= ~p0_hit;
          locked   <= 1'b1;
          cyc_cnt  <= '0;
          word_cnt <= '0;
          miss_cnt <= '0;
        end else if (in_frame) begin
          cyc_cnt <= word_done ? '0 : cyc_cnt + 1'b1;
          if (push) word_cnt <= (state_nx == CHECK) ? '0 : word_cnt + 1'b1;
          if (sync_hit)        miss_cnt <= '0;
          else if (miss_event) miss_cnt <= miss_cnt + 1'b1;
          if (lose_lock) locked <= 1'b0;
        end
      end
    end
  end

  // A push goes straight into the head register only when nothing is queued
  // ahead of it; otherwise it is appended to mem.
  assign pop       = data_valid && data_ready;
  assign full      = data_valid && (mem_cnt == MEM_FULL);
  assign accept    = push && (!full || pop);
  assign mem_empty = (mem_cnt == '0);
  assign mem_rd    = pop && !mem_empty;
  assign mem_wr    = accept && data_valid && !(pop && mem_empty);

  // FIFO storage behind the head
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= word;
  end

  // FIFO head, pointers and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      mem_cnt    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (mem_rd) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end else if (accept && !mem_wr) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (pop) begin
        data_valid <= 1'b0;
      end
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      if (leave_idle)          overflow <= 1'b0;
      else if (push && !accept) overflow <= 1'b1;
    end
  end

`ifdef DDR_RX_ERR_CNT_EN
  // Saturating error statistics, restarted each time the receiver is enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else if (leave_idle) begin
      sync_err_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (miss_event && (sync_err_cnt != 16'hFFFF)) sync_err_cnt  <= sync_err_cnt + 1'b1;
      if (lose_lock && (lock_loss_cnt != 8'hFF))    lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_rx_deser.sv
// tb_ddr_rx_deser
// Self-checking bench for ddr_rx_deser. A bit-stream level reference model
// predicts every output each cycle; directed scenarios add literal checks on
// lock/data latency, word order, flywheel, backpressure, enable and reset.
// Build with DDR_RX_ERR_CNT_EN defined to also cover the error counters.

module tb_ddr_rx_deser;

  localparam int                WORD_W     = 8;
  localparam logic [WORD_W-1:0] SYNC       = 8'hA5;
  localparam int                FRAME_LEN  = 4;
  localparam int                MAX_MISS   = 3;
  localparam int                FIFO_DEPTH = 8;
  localparam int                HALF       = WORD_W / 2;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              ddr_rise;
  logic              ddr_fall;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              locked;
  logic              sync_ok;
  logic              overflow;
`ifdef DDR_RX_ERR_CNT_EN
  logic [15:0]       sync_err_cnt;
  logic [7:0]        lock_loss_cnt;
`endif

  ddr_rx_deser #(
    .WORD_W(WORD_W), .SYNC_WORD(SYNC), .FRAME_LEN(FRAME_LEN),
    .MAX_MISS(MAX_MISS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ddr_rise(ddr_rise), .ddr_fall(ddr_fall),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .locked(locked), .sync_ok(sync_ok), .overflow(overflow)
`ifdef DDR_RX_ERR_CNT_EN
    , .sync_err_cnt(sync_err_cnt), .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The model looks at the received bit history as a plain list of bits and
  // derives word boundaries from the number of cycles elapsed since lock.
  bit                hist[$];
  int                m_mode;
  int                m_since;
  int                m_miss;
  int                m_phase;
  logic [WORD_W-1:0] fq[$];
  logic [WORD_W-1:0] m_out;
  bit                m_locked, m_sync_ok, m_ovf;
  int                m_serr, m_lloss;

  task automatic clearHist();
    hist.delete();
    repeat (WORD_W + 1) hist.push_back(1'b0);
  endtask

  function automatic logic [WORD_W-1:0] winAt(input int off);
    logic [WORD_W-1:0] w;
    int n;
    n = hist.size();
    for (int i = 0; i < WORD_W; i++) w[WORD_W-1-i] = hist[n-WORD_W-off+i];
    return w;
  endfunction

  task automatic modelReset();
    clearHist();
    fq.delete();
    m_mode = 0; m_since = 0; m_miss = 0; m_phase = 0;
    m_out = '0; m_locked = 0; m_sync_ok = 0; m_ovf = 0;
    m_serr = 0; m_lloss = 0;
  endtask

  task automatic modelStep();
    bit                pop;
    bit                pushing;
    logic [WORD_W-1:0] w;
    int                slot;
    pop       = (fq.size() > 0) && (data_ready === 1'b1);
    pushing   = 0;
    w         = '0;
    m_sync_ok = 0;
    if (enable !== 1'b1) begin
      m_mode   = 0;
      m_locked = 0;
      clearHist();
    end else begin
      if (m_mode == 0) begin
        m_mode = 1; m_ovf = 0; m_serr = 0; m_lloss = 0;
      end else if (m_mode == 1) begin
        if (winAt(0) == SYNC || winAt(1) == SYNC) begin
          m_phase  = (winAt(0) == SYNC) ? 0 : 1;
          m_mode   = 2; m_locked = 1; m_since = 0; m_miss = 0;
        end
      end else begin
        m_since++;
        if (m_since % HALF == 0) begin
          slot = (m_since / HALF - 1) % (FRAME_LEN + 1);
          w    = winAt(m_phase);
          if (slot < FRAME_LEN) begin
            pushing = 1;
          end else if (w == SYNC) begin
            m_sync_ok = 1;
            m_miss    = 0;
          end else begin
            m_miss++;
            if (m_serr < 65535) m_serr++;
            if (m_miss >= MAX_MISS) begin
              m_mode = 1; m_locked = 0;
              if (m_lloss < 255) m_lloss++;
            end
          end
        end
      end
      hist.push_back(ddr_rise);
      hist.push_back(ddr_fall);
      while (hist.size() > WORD_W + 1) void'(hist.pop_front());
    end
    if (pop) void'(fq.pop_front());
    if (pushing) begin
      if (fq.size() < FIFO_DEPTH) fq.push_back(w);
      else m_ovf = 1;
    end
    if (fq.size() > 0) m_out = fq[0];
  endtask

  // Model advances on the same edges as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep();
  end

  // Per-cycle comparison against the model, away from the active edge
  task automatic checkOutput();
    expectEq("data_valid", 32'(data_valid), 32'(fq.size() > 0));
    expectEq("data_out",   32'(data_out),   32'(m_out));
    expectEq("locked",     32'(locked),     32'(m_locked));
    expectEq("sync_ok",    32'(sync_ok),    32'(m_sync_ok));
    expectEq("overflow",   32'(overflow),   32'(m_ovf));
`ifdef DDR_RX_ERR_CNT_EN
    expectEq("sync_err_cnt",  32'(sync_err_cnt),  32'(m_serr));
    expectEq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_lloss));
`endif
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) checkOutput();
  end

  // ---------------- monitors for the directed literal checks ----------------
  logic [WORD_W-1:0] pop_log[$];
  int                lock_edge, dv_edge, sync_cnt;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (data_valid && data_ready) pop_log.push_back(data_out);
      if (locked && lock_edge < 0) lock_edge = cyc;
      if (data_valid && dv_edge < 0) dv_edge = cyc;
      if (sync_ok) sync_cnt++;
    end
  end

  task automatic clearMon();
    pop_log.delete();
    lock_edge = -1;
    dv_edge   = -1;
    sync_cnt  = 0;
  endtask

  // ---------------- stimulus ----------------
  bit tx[$];
  bit rand_ready = 0;
  int t0;

  task automatic applyStimulus(input bit en, input bit r, input bit f);
    @(posedge clk);
    #2;
    enable   = en;
    ddr_rise = r;
    ddr_fall = f;
    if (rand_ready) data_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic addBits(input logic [WORD_W-1:0] w, input int nbits);
    for (int i = WORD_W - 1; i >= WORD_W - nbits; i--) tx.push_back(w[i]);
  endtask

  task automatic addWord(input logic [WORD_W-1:0] w);
    addBits(w, WORD_W);
  endtask

  task automatic sendStream();
    bit first;
    first = 1;
    while (tx.size() > 0) begin
      bit r, f;
      r = tx.pop_front();
      f = (tx.size() > 0) ? tx.pop_front() : 1'b0;
      applyStimulus(1, r, f);
      if (first) t0 = cyc + 1;
      first = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1, 0, 0);
  endtask

  task automatic disableFor(input int n);
    repeat (n) applyStimulus(0, 0, 0);
  endtask

  task automatic checkLog(input string name, input int idx, input logic [WORD_W-1:0] exp);
    if (idx < pop_log.size()) expectEq(name, 32'(pop_log[idx]), 32'(exp));
    else expectEq({name, "_missing"}, 32'(pop_log.size()), 32'(idx + 1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; ddr_rise = 1'b0; ddr_fall = 1'b0; data_ready = 1'b1;
    clearMon();
    repeat (3) @(posedge clk);
    #1;
    expectEq("rst_data_out",   32'(data_out),   32'h0);
    expectEq("rst_data_valid", 32'(data_valid), 32'h0);
    expectEq("rst_locked",     32'(locked),     32'h0);
    expectEq("rst_sync_ok",    32'(sync_ok),    32'h0);
    expectEq("rst_overflow",   32'(overflow),   32'h0);
    #1;
    rst = 1'b0;

    // Phase 0 aligned frame
    $display("[TB] phase 0 aligned frame");
    disableFor(2); idle(3); clearMon();
    addWord(8'hA5); addWord(8'h11); addWord(8'h22); addWord(8'h33); addWord(8'h44); addWord(8'hA5);
    sendStream(); idle(6);
    expectEq("p0_lock_edge", 32'(lock_edge), 32'(t0 + 4));
    expectEq("p0_dv_edge",   32'(dv_edge),   32'(t0 + 8));
    checkLog("p0_w0", 0, 8'h11); checkLog("p0_w1", 1, 8'h22);
    checkLog("p0_w2", 2, 8'h33); checkLog("p0_w3", 3, 8'h44);
    expectEq("p0_sync_pulses", 32'(sync_cnt), 32'd1);
    expectEq("p0_overflow",    32'(overflow), 32'd0);

    // Phase 1: one leading zero bit
    $display("[TB] phase 1 frame");
    disableFor(12); idle(3); clearMon();
    tx.push_back(1'b0);
    addWord(8'hA5); addWord(8'h11); addWord(8'h22); addWord(8'h33); addWord(8'h44); addWord(8'hA5);
    sendStream(); idle(6);
    expectEq("p1_lock_edge", 32'(lock_edge), 32'(t0 + 5));
    expectEq("p1_dv_edge",   32'(dv_edge),   32'(t0 + 9));
    checkLog("p1_w0", 0, 8'h11); checkLog("p1_w3", 3, 8'h44);
    expectEq("p1_sync_pulses", 32'(sync_cnt), 32'd1);

    // Flywheel over two bad syncs, loss of lock on the third, relock
    $display("[TB] flywheel and loss of lock");
    disableFor(12); idle(3); clearMon();
    addWord(8'hA5);
    for (int fr = 0; fr < 3; fr++) begin
      for (int k = 1; k <= FRAME_LEN; k++) addWord(8'(fr * FRAME_LEN + k));
      addWord(8'h5A);
    end
    sendStream(); idle(3);
    expectEq("fly_locked_after_3", 32'(locked), 32'd0);
    expectEq("fly_word_count", 32'(pop_log.size()), 32'd12);
    for (int k = 0; k < 12; k++) checkLog("fly_word", k, 8'(k + 1));
`ifdef DDR_RX_ERR_CNT_EN
    expectEq("fly_sync_err_cnt",  32'(sync_err_cnt),  32'd3);
    expectEq("fly_lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif
    addWord(8'hA5); addWord(8'h21); addWord(8'h22); addWord(8'h23); addWord(8'h24); addWord(8'hA5);
    sendStream(); idle(6);
    expectEq("relock_locked", 32'(locked), 32'd1);
    checkLog("relock_w0", 12, 8'h21);
    checkLog("relock_w3", 15, 8'h24);
`ifdef DDR_RX_ERR_CNT_EN
    disableFor(2); idle(3);
    expectEq("cnt_clear_serr",  32'(sync_err_cnt),  32'd0);
    expectEq("cnt_clear_lloss", 32'(lock_loss_cnt), 32'd0);
`endif

    // Backpressure across three frames
    $display("[TB] backpressure");
    disableFor(12); data_ready = 1'b0; idle(3); clearMon();
    addWord(8'hA5);
    for (int fr = 0; fr < 3; fr++) begin
      for (int k = 1; k <= FRAME_LEN; k++) addWord(8'(fr * FRAME_LEN + k));
      addWord(8'hA5);
    end
    sendStream(); idle(2);
    expectEq("bp_overflow", 32'(overflow),   32'd1);
    expectEq("bp_valid",    32'(data_valid), 32'd1);
    data_ready = 1'b1;
    disableFor(12);
    expectEq("bp_drained", 32'(pop_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) checkLog("bp_word", k, 8'(k + 1));
    expectEq("bp_valid_after", 32'(data_valid), 32'd0);
    expectEq("bp_ovf_sticky",  32'(overflow),   32'd1);

    // Enable dropped mid-word
    $display("[TB] enable low mid-word");
    idle(3); clearMon();
    addWord(8'hA5); addWord(8'h31); addWord(8'h32); addBits(8'h33, 4);
    sendStream(); disableFor(2); idle(3);
    addWord(8'hA5); addWord(8'h41); addWord(8'h42); addWord(8'h43); addWord(8'h44); addWord(8'hA5);
    sendStream(); idle(6);
    checkLog("en_w0", 0, 8'h31); checkLog("en_w1", 1, 8'h32);
    checkLog("en_w2", 2, 8'h41); checkLog("en_w3", 3, 8'h42);
    checkLog("en_w4", 4, 8'h43); checkLog("en_w5", 5, 8'h44);

    // Asynchronous reset mid-word
    $display("[TB] reset mid-word");
    addWord(8'h51); addWord(8'h52); addBits(8'h53, 4);
    sendStream();
    #1;
    rst = 1'b1;
    #1;
    expectEq("arst_data_out",   32'(data_out),   32'h0);
    expectEq("arst_data_valid", 32'(data_valid), 32'h0);
    expectEq("arst_locked",     32'(locked),     32'h0);
    expectEq("arst_sync_ok",    32'(sync_ok),    32'h0);
    expectEq("arst_overflow",   32'(overflow),   32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Randomised frames, corrupted syncs, phase slips, enable drops, backpressure
    $display("[TB] random traffic");
    rand_ready = 1;
    idle(3);
    for (int fr = 0; fr < 150; fr++) begin
      if ($urandom_range(0, 7) == 0) begin
        disableFor($urandom_range(1, 3));
        idle(2);
      end
      if ($urandom_range(0, 3) == 0) tx.push_back(1'b0);
      if ($urandom_range(0, 3) == 0) addWord(SYNC ^ 8'($urandom_range(1, 255)));
      else addWord(SYNC);
      for (int k = 0; k < FRAME_LEN; k++) addWord(8'($urandom_range(0, 255)));
      sendStream();
    end
    rand_ready = 0;
    data_ready = 1'b1;
    disableFor(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
